// File: rtl/gcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gcd_ctrl
// Description : Moore controller sequencing a subtractive GCD datapath:
//               load, compare/subtract loop, result capture, done pulse,
//               with a bounded iteration count that traps into an error state.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_ctrl #(
    parameter  int MAX_ITER = 16,
    localparam int ITW      = $clog2(MAX_ITER + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic           x_eq_y,
    input  logic           x_gt_y,
    input  logic           x_zero,
    input  logic           y_zero,
    output logic           sel_x,
    output logic           sel_y,
    output logic           ld_x,
    output logic           ld_y,
    output logic           ld_gcd,
    output logic           gcd_sel,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [ITW-1:0] iter_cnt
);

    localparam logic [ITW-1:0] c_max_iter = ITW'(MAX_ITER);
    localparam logic [ITW-1:0] c_one      = ITW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CMP    = 3'd2,
        S_SUB_X  = 3'd3,
        S_SUB_Y  = 3'd4,
        S_FINISH = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t         state_q, state_d;
    logic [ITW-1:0] iter_q, iter_d;
    logic           gcd_sel_q, gcd_sel_d;
    logic           sel_x_q, sel_x_d;
    logic           sel_y_q, sel_y_d;
    logic           ld_x_q, ld_x_d;
    logic           ld_y_q, ld_y_d;
    logic           ld_gcd_q, ld_gcd_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           w_busy_now;

    assign w_busy_now = state_q inside {S_LOAD, S_CMP, S_SUB_X, S_SUB_Y, S_FINISH};

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        gcd_sel_d = gcd_sel_q;

        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD;
            S_ERR:    if (start) state_d = S_LOAD;
            S_LOAD:   state_d = S_CMP;
            S_CMP: begin
                if (y_zero || x_eq_y) begin
                    state_d   = S_FINISH;
                    gcd_sel_d = 1'b0;
                end else if (x_zero) begin
                    state_d   = S_FINISH;
                    gcd_sel_d = 1'b1;
                end else if (iter_q == c_max_iter) begin
                    state_d = S_ERR;
                end else if (x_gt_y) begin
                    state_d = S_SUB_X;
                end else begin
                    state_d = S_SUB_Y;
                end
            end
            S_SUB_X:  state_d = S_CMP;
            S_SUB_Y:  state_d = S_CMP;
            S_FINISH: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Abort beats every other transition and leaves the result source untouched.
        if (abort && w_busy_now) begin
            state_d   = S_IDLE;
            gcd_sel_d = gcd_sel_q;
        end

        if (state_d == S_LOAD) begin
            iter_d = '0;
        end else if ((state_d == S_SUB_X || state_d == S_SUB_Y) && iter_q != c_max_iter) begin
            iter_d = iter_q + c_one;
        end

        // Outputs are decoded from the next state so they register in step with it.
        sel_x_d  = (state_d == S_SUB_X);
        sel_y_d  = (state_d == S_SUB_Y);
        ld_x_d   = (state_d == S_LOAD) || (state_d == S_SUB_X);
        ld_y_d   = (state_d == S_LOAD) || (state_d == S_SUB_Y);
        ld_gcd_d = (state_d == S_FINISH);
        busy_d   = state_d inside {S_LOAD, S_CMP, S_SUB_X, S_SUB_Y, S_FINISH};
        done_d   = (state_d == S_DONE);
        err_d    = (state_d == S_ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            iter_q    <= '0;
            gcd_sel_q <= 1'b0;
            sel_x_q   <= 1'b0;
            sel_y_q   <= 1'b0;
            ld_x_q    <= 1'b0;
            ld_y_q    <= 1'b0;
            ld_gcd_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            gcd_sel_q <= gcd_sel_d;
            sel_x_q   <= sel_x_d;
            sel_y_q   <= sel_y_d;
            ld_x_q    <= ld_x_d;
            ld_y_q    <= ld_y_d;
            ld_gcd_q  <= ld_gcd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign sel_x    = sel_x_q;
    assign sel_y    = sel_y_q;
    assign ld_x     = ld_x_q;
    assign ld_y     = ld_y_q;
    assign ld_gcd   = ld_gcd_q;
    assign gcd_sel  = gcd_sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign iter_cnt = iter_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_ctrl
// Description : Self-checking bench: two controllers (MAX_ITER 16 and 4) each
//               driving a behavioural 4-bit datapath, checked against a GCD model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_ctrl;

    localparam int M0 = 16;
    localparam int M1 = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] start = '0;
    logic [1:0] abort = '0;
    logic [1:0] x_eq_y, x_gt_y, x_zero, y_zero;
    wire  [1:0] sel_x, sel_y, ld_x, ld_y, ld_gcd, gcd_sel, busy, done, err;
    wire  [4:0] ic0;
    wire  [2:0] ic1;
    logic [3:0] xin[2], yin[2], xr[2], yr[2], gr[2];
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    gcd_ctrl #(.MAX_ITER(M0)) u_dut16 (
        .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
        .x_eq_y(x_eq_y[0]), .x_gt_y(x_gt_y[0]), .x_zero(x_zero[0]), .y_zero(y_zero[0]),
        .sel_x(sel_x[0]), .sel_y(sel_y[0]), .ld_x(ld_x[0]), .ld_y(ld_y[0]),
        .ld_gcd(ld_gcd[0]), .gcd_sel(gcd_sel[0]), .busy(busy[0]), .done(done[0]),
        .err(err[0]), .iter_cnt(ic0)
    );

    gcd_ctrl #(.MAX_ITER(M1)) u_dut4 (
        .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
        .x_eq_y(x_eq_y[1]), .x_gt_y(x_gt_y[1]), .x_zero(x_zero[1]), .y_zero(y_zero[1]),
        .sel_x(sel_x[1]), .sel_y(sel_y[1]), .ld_x(ld_x[1]), .ld_y(ld_y[1]),
        .ld_gcd(ld_gcd[1]), .gcd_sel(gcd_sel[1]), .busy(busy[1]), .done(done[1]),
        .err(err[1]), .iter_cnt(ic1)
    );

    // Behavioural datapath for each controller
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ld_x[i])   xr[i] <= sel_x[i] ? xr[i] - yr[i] : xin[i];
            if (ld_y[i])   yr[i] <= sel_y[i] ? yr[i] - xr[i] : yin[i];
            if (ld_gcd[i]) gr[i] <= gcd_sel[i] ? yr[i] : xr[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            x_eq_y[i] = (xr[i] == yr[i]);
            x_gt_y[i] = (xr[i] > yr[i]);
            x_zero[i] = (xr[i] == 4'd0);
            y_zero[i] = (yr[i] == 4'd0);
        end
    end

    function automatic int icnt(input int idx);
        return (idx == 0) ? int'(ic0) : int'(ic1);
    endfunction

    function automatic logic [8:0] outs(input int idx);
        return {sel_x[idx], sel_y[idx], ld_x[idx], ld_y[idx], ld_gcd[idx],
                gcd_sel[idx], busy[idx], done[idx], err[idx]};
    endfunction

    // Reference: Euclid by repeated subtraction, with the step budget
    function automatic void ref_gcd(input int x, input int y, input int m,
                                    output int res, output int sel, output int n, output int erred);
        n = 0; erred = 0; res = 0; sel = 0;
        while (1) begin
            if (y == 0 || x == y) begin res = x; sel = 0; return; end
            if (x == 0) begin res = y; sel = 1; return; end
            if (n == m) begin erred = 1; return; end
            if (x > y) x = x - y;
            else       y = y - x;
            n++;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        start = '0;
        abort = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Starts a run in the current cycle; returns in the IDLE cycle after DONE, or in the ERR cycle.
    task automatic run_case(input int idx, input int x, input int y, input bit hold);
        int m, res, sel, n, erred, exp_end, end_k;
        m = (idx == 0) ? M0 : M1;
        ref_gcd(x, y, m, res, sel, n, erred);
        exp_end = (erred != 0) ? 3 + 2 * m : 4 + 2 * n;
        xin[idx] = 4'(x);
        yin[idx] = 4'(y);
        start[idx] = 1'b1;
        end_k = 0;
        for (int k = 1; k <= exp_end + 3; k++) begin
            tick();
            if (!hold) start[idx] = 1'b0;
            if (k == 1) begin
                vectors++;
                if ({ld_x[idx], ld_y[idx], sel_x[idx], sel_y[idx], err[idx]} !== 5'b11000) begin
                    miscompares++;
                    $display("FAIL load_cycle dut%0d x=%0d y=%0d: got %b, expected 11000", idx, x, y,
                             {ld_x[idx], ld_y[idx], sel_x[idx], sel_y[idx], err[idx]});
                end
            end
            vectors++;
            if (busy[idx] !== (k < exp_end)) begin
                miscompares++;
                $display("FAIL busy dut%0d x=%0d y=%0d cyc=%0d: got %b, expected %b", idx, x, y, k,
                         busy[idx], (k < exp_end));
            end
            vectors++;
            if (ld_gcd[idx] !== (erred == 0 && k == exp_end - 1)) begin
                miscompares++;
                $display("FAIL ld_gcd dut%0d x=%0d y=%0d cyc=%0d: got %b, expected %b", idx, x, y, k,
                         ld_gcd[idx], (erred == 0 && k == exp_end - 1));
            end
            if (done[idx] === 1'b1 || err[idx] === 1'b1) begin
                end_k = k;
                break;
            end
        end
        vectors++;
        if (end_k != exp_end) begin
            miscompares++;
            $display("FAIL latency dut%0d x=%0d y=%0d: ended at cycle %0d, expected %0d (0 = timeout)",
                     idx, x, y, end_k, exp_end);
        end else begin
            vectors++;
            if ({done[idx], err[idx]} !== {erred == 0, erred != 0}) begin
                miscompares++;
                $display("FAIL done_err dut%0d x=%0d y=%0d: got %b%b, expected %b%b", idx, x, y,
                         done[idx], err[idx], erred == 0, erred != 0);
            end
            vectors++;
            if (icnt(idx) != ((erred != 0) ? m : n)) begin
                miscompares++;
                $display("FAIL iter_cnt dut%0d x=%0d y=%0d: got %0d, expected %0d", idx, x, y,
                         icnt(idx), (erred != 0) ? m : n);
            end
            if (erred == 0) begin
                vectors++;
                if (gr[idx] !== 4'(res)) begin
                    miscompares++;
                    $display("FAIL gcd_out dut%0d x=%0d y=%0d: got %0d, expected %0d", idx, x, y, gr[idx], res);
                end
                vectors++;
                if (gcd_sel[idx] !== 1'(sel)) begin
                    miscompares++;
                    $display("FAIL gcd_sel dut%0d x=%0d y=%0d: got %b, expected %0d", idx, x, y, gcd_sel[idx], sel);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (outs(i) !== 9'b0 || icnt(i) != 0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got outs=%b iter=%0d, expected all zero", i, outs(i), icnt(i));
            end
        end
        apply_reset();
    endtask

    task automatic test_equal_operands();
        apply_reset();
        run_case(0, 6, 6, 0);
    endtask

    task automatic test_subtract_sequence();
        apply_reset();
        run_case(0, 12, 8, 0);
        run_case(0, 15, 1, 0);
        run_case(0, 9, 15, 0);
    endtask

    task automatic test_zero_operands();
        apply_reset();
        run_case(0, 0, 9, 0);
        run_case(0, 0, 0, 0);
        run_case(0, 7, 0, 0);
    endtask

    task automatic test_iteration_limit();
        apply_reset();
        run_case(1, 15, 1, 0);
        run_case(1, 15, 1, 0);
        run_case(1, 6, 4, 0);
    endtask

    task automatic test_abort();
        apply_reset();
        xin[0] = 4'd12;
        yin[0] = 4'd8;
        start[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            start[0] = 1'b0;
        end
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        vectors++;
        if (outs(0) !== 9'b0 || icnt(0) != 1) begin
            miscompares++;
            $display("FAIL abort_idle: got outs=%b iter=%0d, expected outs=0 iter=1", outs(0), icnt(0));
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            vectors++;
            if (busy[0] !== 1'b0 || done[0] !== 1'b0 || ld_gcd[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_quiet cyc=%0d: got busy/done/ld_gcd=%b%b%b, expected 000", k,
                         busy[0], done[0], ld_gcd[0]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        xin[0] = 4'd12;
        yin[0] = 4'd8;
        start[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            start[0] = 1'b0;
        end
        reset = 1'b1;
        #2;
        vectors++;
        if (outs(0) !== 9'b0 || icnt(0) != 0) begin
            miscompares++;
            $display("FAIL reset_midrun: got outs=%b iter=%0d, expected all zero", outs(0), icnt(0));
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (outs(0) !== 9'b0) begin
                miscompares++;
                $display("FAIL reset_quiet cyc=%0d: got outs=%b, expected all zero", k, outs(0));
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_case(0, 12, 8, 1);
        vectors++;
        if (busy[0] !== 1'b0 || ld_x[0] !== 1'b0 || done[0] !== 1'b0 || icnt(0) != 2) begin
            miscompares++;
            $display("FAIL b2b_idle: got busy/ld_x/done=%b%b%b iter=%0d, expected 000 iter=2",
                     busy[0], ld_x[0], done[0], icnt(0));
        end
        tick();
        vectors++;
        if (busy[0] !== 1'b1 || ld_x[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_reload: got busy/ld_x=%b%b, expected 11", busy[0], ld_x[0]);
        end
        start[0] = 1'b0;
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        vectors++;
        if (busy[0] !== 1'b0 || ld_x[0] !== 1'b0 || ld_y[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_in_load: got busy/ld_x/ld_y=%b%b%b, expected 000", busy[0], ld_x[0], ld_y[0]);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int r = 0; r < 40; r++) begin
            int idx;
            idx = (r < 26) ? 0 : 1;
            if (r == 26) apply_reset();
            run_case(idx, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        start = '0;
    endtask

    initial begin
        #1;
        test_reset();
        test_equal_operands();
        test_subtract_sequence();
        test_zero_operands();
        test_iteration_limit();
        test_abort();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
